fanin_resp_arb_bridge: RTL and testbench
========================================

Name: fanin_resp_arb_bridge

Overview:
- N-channel successor to the 2:1 response fan-in used on the XBAR bridge return path.
- Merges N_CH upstream response streams (rdata/rtag/opc/aux) into one downstream stream.
- Per-channel FIFO buffering absorbs simultaneous responses instead of requiring mutual exclusion.
- Round-robin arbitration, registered output with valid/ready backpressure, source-channel ID and per-channel overflow flags.

Parameters:
- N_CH, 4, number of upstream response channels (>=2)
- DATA_WIDTH, 32, rdata width
- AUX_WIDTH, 6, aux width
- BYTE_NUM, DATA_WIDTH/8, bytes per word
- TAG_WIDTH, BYTE_NUM, rtag width
- DEPTH, 2, per-channel FIFO entries (power of two, >=2)
- CH_W, (N_CH>1 ? $clog2(N_CH) : 1), source-ID width (derived, do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_r_rdata_i  in  N_CH*DATA_WIDTH  per-channel rdata, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- data_r_rtag_i  in  N_CH*TAG_WIDTH  per-channel rtag
- data_r_opc_i  in  N_CH  per-channel opc
- data_r_aux_i  in  N_CH*AUX_WIDTH  per-channel aux
- data_r_valid_i  in  N_CH  per-channel response valid
- data_r_ready_o  out  N_CH  per-channel FIFO not full
- data_r_rdata_o  out  DATA_WIDTH  merged rdata
- data_r_rtag_o  out  TAG_WIDTH  merged rtag
- data_r_opc_o  out  1  merged opc
- data_r_aux_o  out  AUX_WIDTH  merged aux
- data_r_id_o  out  CH_W  source channel of current output
- data_r_valid_o  out  1  output valid
- data_r_ready_i  in  1  downstream ready
- overflow_o  out  N_CH  sticky per-channel overflow flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - All FIFOs empty, so data_r_ready_o = all 1s one cycle after rst deasserts; held at 0 while rst is high.
  - data_r_valid_o = 0; data_r_rdata_o, data_r_rtag_o, data_r_opc_o, data_r_aux_o and data_r_id_o = 0.
  - overflow_o = 0; round-robin pointer = N_CH-1, so channel 0 has first priority.
- Input push:
  - Channel k pushes on a rising edge with data_r_valid_i[k] & data_r_ready_o[k].
  - data_r_ready_o[k] = !full[k], taken from registered state only. No same-cycle pass-through and no push into a full FIFO even if it is popped that cycle.
- Overflow: data_r_valid_i[k] & !data_r_ready_o[k] drops the beat and sets overflow_o[k]. The flag stays set until rst.
- Arbitration:
  - Candidates are non-empty FIFOs.
  - Grant goes to the first candidate searching from pointer+1 upward, with modulo N_CH wrap-around.
  - The pointer updates to the granted index only when a load occurs.
- Output register:
  - load = any candidate & (!data_r_valid_o | data_r_ready_i).
  - On load, the granted FIFO head is popped into the output registers, data_r_id_o = granted index, and data_r_valid_o = 1.
  - If data_r_valid_o & data_r_ready_i and there is no candidate, data_r_valid_o goes to 0. Data outputs hold their last value.
  - While data_r_valid_o & !data_r_ready_i, all outputs are stable and no FIFO is popped.
- Latency and throughput:
  - A beat pushed on edge t appears on the output from cycle t+2 (minimum 2 cycles).
  - Sustained throughput is 1 beat/cycle with ready held high.
- Ordering: per-channel order is preserved; no ordering guarantee across channels.
- FIFO: read/write pointers of $clog2(DEPTH)+1 bits; full/empty from MSB compare; wrap-around is natural binary.
- Reset mid-operation: all buffered and output beats are discarded. Nothing is emitted after rst.

Decomposition:
- Package fanin_resp_bridge_pkg holds:
  - the function clog2_min1(n);
  - rr_next(ptr, req, n), a combinational round-robin search helper.
- Payload concatenation order is {opc, aux, rtag, rdata}; the width is computed locally because it is parameter-dependent.
- Sub-module resp_fifo_bridge: single-clock FIFO, parameters WIDTH and DEPTH, ports clk/rst/push/pop/wdata/rdata/full/empty. It is instantiated N_CH times via generate.

Test Plan:
- Reset, then a single beat on channel 2 (rdata=0xDEADBEEF, tag=0xA, aux=0x15, opc=1), ready=1 -> output 2 cycles later with id=2 and identical fields; valid high for exactly 1 cycle.
- All 4 channels valid in the same cycle for 1 cycle, ready=1 -> outputs in id order 0,1,2,3 on consecutive cycles; no overflow.
- Channels 0 and 3 valid continuously, ready=1 -> output ids alternate 0,3,0,3; each data_r_ready_o deasserts once its FIFO fills (2 entries plus arbitration lag).
- ready=0 with channel 1 pushing 3 beats (0x1, 0x2, 0x3) -> output holds 0x1 stable; FIFO fills with 0x2, 0x3 and data_r_ready_o[1]=0; a 4th push 0x4 sets overflow_o[1]=1. After ready=1, output is 0x1, 0x2, 0x3; 0x4 is never seen.
- Continuous traffic on all channels, ready toggled 1/0 at random -> per-channel sequence numbers arrive in order; no beat lost while ready_o was high; output is stable while stalled.
- rst asserted for 1 cycle with FIFOs and the output register full -> next cycle valid_o=0, overflow_o=0, ready_o=0 while rst is high, then all 1s; no stale beat emitted.

Source files
------------

// File: rtl/fanin_resp_bridge_pkg.sv
// Shared helpers for the N-channel response fan-in bridge.
package fanin_resp_bridge_pkg;

  localparam int RR_MAX = 32;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req after ptr, wrapping modulo n; returns ptr when req is empty.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [RR_MAX-1:0] req,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      if (!found && i <= n) begin
        idx = (ptr + i) % n;
        if (req[idx[4:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/resp_fifo_bridge.sv
// Single-clock per-channel response FIFO; pointers carry one extra wrap bit.
module resp_fifo_bridge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/fanin_resp_arb_bridge.sv
// N-channel response fan-in: per-channel FIFOs, round-robin pick, registered
// valid/ready output with source ID and sticky per-channel overflow flags.
module fanin_resp_arb_bridge
  import fanin_resp_bridge_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AUX_WIDTH  = 6,
  parameter int BYTE_NUM   = DATA_WIDTH / 8,
  parameter int TAG_WIDTH  = BYTE_NUM,
  parameter int DEPTH      = 2,
  parameter int CH_W       = clog2_min1(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic [N_CH*TAG_WIDTH-1:0]  data_r_rtag_i,
  input  logic [N_CH-1:0]            data_r_opc_i,
  input  logic [N_CH*AUX_WIDTH-1:0]  data_r_aux_i,
  input  logic [N_CH-1:0]            data_r_valid_i,
  output logic [N_CH-1:0]            data_r_ready_o,
  output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]       data_r_rtag_o,
  output logic                       data_r_opc_o,
  output logic [AUX_WIDTH-1:0]       data_r_aux_o,
  output logic [CH_W-1:0]            data_r_id_o,
  output logic                       data_r_valid_o,
  input  logic                       data_r_ready_i,
  output logic [N_CH-1:0]            overflow_o
);
  localparam int PW = 1 + AUX_WIDTH + TAG_WIDTH + DATA_WIDTH;

  logic [N_CH-1:0]          full, empty, push, pop;
  logic [N_CH-1:0][PW-1:0]  fifo_rdata;
  logic                     rdy_en;
  logic [CH_W-1:0]          rr_ptr, gnt;
  logic                     any_req, load;

  // rdy_en keeps ready low through reset; full comes from FIFO pointer registers.
  assign data_r_ready_o = ~full & {N_CH{rdy_en}};
  assign push           = data_r_valid_i & data_r_ready_o;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    resp_fifo_bridge #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .wdata ({data_r_opc_i[k],
               data_r_aux_i[k*AUX_WIDTH +: AUX_WIDTH],
               data_r_rtag_i[k*TAG_WIDTH +: TAG_WIDTH],
               data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH]}),
      .rdata (fifo_rdata[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  always_comb begin
    any_req = |(~empty);
    gnt     = CH_W'(rr_next(32'(rr_ptr), RR_MAX'(~empty), N_CH));
    load    = any_req && (!data_r_valid_o || data_r_ready_i);
    pop     = load ? (N_CH'(1) << gnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en         <= 1'b0;
      rr_ptr         <= CH_W'(N_CH - 1);
      data_r_valid_o <= 1'b0;
      data_r_rdata_o <= '0;
      data_r_rtag_o  <= '0;
      data_r_opc_o   <= 1'b0;
      data_r_aux_o   <= '0;
      data_r_id_o    <= '0;
      overflow_o     <= '0;
    end else begin
      rdy_en     <= 1'b1;
      overflow_o <= overflow_o | (data_r_valid_i & ~data_r_ready_o);
      if (load) begin
        {data_r_opc_o, data_r_aux_o, data_r_rtag_o, data_r_rdata_o} <= fifo_rdata[gnt];
        data_r_id_o    <= gnt;
        data_r_valid_o <= 1'b1;
        rr_ptr         <= gnt;
      end else if (data_r_ready_i) begin
        // No candidate: a consumed beat leaves the register empty, data held.
        data_r_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fanin_resp_arb_bridge.sv
// Randomized bench for fanin_resp_arb_bridge against a queue-based cycle model.
module tb_fanin_resp_arb_bridge;
  localparam int N_CH = 4, DW = 32, AXW = 6, TW = 4, DEPTH = 2, CH_W = 2;
  localparam int PW = 1 + AXW + TW + DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH*DW-1:0]   rdata_i;
  logic [N_CH*TW-1:0]   rtag_i;
  logic [N_CH-1:0]      opc_i;
  logic [N_CH*AXW-1:0]  aux_i;
  logic [N_CH-1:0]      valid_i;
  logic [N_CH-1:0]      ready_o;
  logic [DW-1:0]        rdata_o;
  logic [TW-1:0]        rtag_o;
  logic                 opc_o;
  logic [AXW-1:0]       aux_o;
  logic [CH_W-1:0]      id_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [N_CH-1:0]      ovf_o;

  fanin_resp_arb_bridge #(.N_CH(N_CH), .DATA_WIDTH(DW), .AUX_WIDTH(AXW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .data_r_rdata_i(rdata_i), .data_r_rtag_i(rtag_i), .data_r_opc_i(opc_i),
    .data_r_aux_i(aux_i), .data_r_valid_i(valid_i), .data_r_ready_o(ready_o),
    .data_r_rdata_o(rdata_o), .data_r_rtag_o(rtag_o), .data_r_opc_o(opc_o),
    .data_r_aux_o(aux_o), .data_r_id_o(id_o), .data_r_valid_o(valid_o),
    .data_r_ready_i(ready_i), .overflow_o(ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue of beats per channel plus the output register.
  logic [PW-1:0]   mq [N_CH][$];
  logic            m_valid, m_rdy_en, m_on = 1'b0;
  logic [PW-1:0]   m_out;
  int              m_id, m_ptr;
  logic [N_CH-1:0] m_ovf;

  task automatic model_edge();
    logic [N_CH-1:0] acc;
    int g, c;
    if (rst) begin
      for (int k = 0; k < N_CH; k++) mq[k].delete();
      m_valid = 0; m_out = '0; m_id = 0; m_ptr = N_CH - 1; m_ovf = '0; m_rdy_en = 0; m_on = 1;
      return;
    end
    if (!m_on) return;
    for (int k = 0; k < N_CH; k++) acc[k] = m_rdy_en && (mq[k].size() < DEPTH);
    g = -1;
    if (!m_valid || ready_i)
      for (int i = 1; i <= N_CH; i++) begin
        c = (m_ptr + i) % N_CH;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
    if (g >= 0) begin
      m_out = mq[g].pop_front(); m_id = g; m_valid = 1; m_ptr = g;
    end else if (ready_i) m_valid = 0;
    for (int k = 0; k < N_CH; k++)
      if (valid_i[k]) begin
        if (acc[k]) mq[k].push_back({opc_i[k], aux_i[k*AXW +: AXW], rtag_i[k*TW +: TW], rdata_i[k*DW +: DW]});
        else m_ovf[k] = 1;
      end
    m_rdy_en = 1;
  endtask

  // One clock: model follows the edge, DUT compared half a cycle later.
  task automatic step();
    logic [N_CH-1:0] er;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_on) begin
      for (int k = 0; k < N_CH; k++) er[k] = m_rdy_en && (mq[k].size() < DEPTH);
      chk("valid_o", valid_o, m_valid);
      chk("rdata_o", rdata_o, m_out[DW-1:0]);
      chk("rtag_o", rtag_o, m_out[DW +: TW]);
      chk("aux_o", aux_o, m_out[DW+TW +: AXW]);
      chk("opc_o", opc_o, m_out[PW-1]);
      chk("id_o", id_o, m_id);
      chk("ready_o", ready_o, er);
      chk("overflow_o", ovf_o, m_ovf);
    end
  endtask

  task automatic drive(input int k, input logic [DW-1:0] d, input logic [TW-1:0] t,
                       input logic [AXW-1:0] a, input logic o, input logic v);
    rdata_i[k*DW +: DW] = d;
    rtag_i[k*TW +: TW]  = t;
    aux_i[k*AXW +: AXW] = a;
    opc_i[k]            = o;
    valid_i[k]          = v;
  endtask

  task automatic do_reset();
    rst = 1; valid_i = '0;
    step();
    rst = 0;
    step();
  endtask

  int seq [N_CH];
  logic v;

  initial begin
    rst = 1; ready_i = 1; valid_i = '0; rdata_i = '0; rtag_i = '0; opc_i = '0; aux_i = '0;
    @(negedge clk);
    step();
    chk("rst_ready_low", ready_o, 4'h0);
    chk("rst_valid", valid_o, 1'b0);
    rst = 0;
    step();
    chk("rst_ready_high", ready_o, 4'hF);

    // Single beat on channel 2.
    drive(2, 32'hDEADBEEF, 4'hA, 6'h15, 1'b1, 1'b1);
    step();
    valid_i = '0;
    step();
    chk("t1_valid", valid_o, 1'b1);
    chk("t1_rdata", rdata_o, 32'hDEADBEEF);
    chk("t1_id", id_o, 2);
    chk("t1_tag", rtag_o, 4'hA);
    chk("t1_aux", aux_o, 6'h15);
    chk("t1_opc", opc_o, 1'b1);
    step();
    chk("t1_single", valid_o, 1'b0);

    // All channels at once: drained in id order after reset.
    do_reset();
    for (int k = 0; k < N_CH; k++) drive(k, 32'h100 + k, TW'(k), AXW'(k), k[0], 1'b1);
    step();
    valid_i = '0;
    for (int i = 0; i < N_CH; i++) begin
      step();
      chk("t2_id", id_o, i);
      chk("t2_rdata", rdata_o, 32'h100 + i);
    end
    chk("t2_ovf", ovf_o, 4'h0);

    // Channels 0 and 3 streaming: grants alternate.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 32'h1000 + i, 4'h1, 6'h1, 1'b0, 1'b1);
      drive(3, 32'h3000 + i, 4'h3, 6'h3, 1'b1, 1'b1);
      step();
      if (i >= 1) chk("t3_id", id_o, (i % 2 == 1) ? 0 : 3);
    end
    valid_i = '0;
    repeat (6) step();

    // Stall with channel 1 pushing four beats: the fourth overflows.
    do_reset();
    ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, DW'(i), 4'h0, 6'h0, 1'b0, 1'b1);
      step();
    end
    valid_i = '0;
    chk("t4_ovf", ovf_o[1], 1'b1);
    chk("t4_full", ready_o[1], 1'b0);
    chk("t4_hold", rdata_o, 32'h1);
    step();
    chk("t4_stable", rdata_o, 32'h1);
    chk("t4_stable_v", valid_o, 1'b1);
    ready_i = 1;
    step(); chk("t4_b2", rdata_o, 32'h2);
    step(); chk("t4_b3", rdata_o, 32'h3);
    step(); chk("t4_end", valid_o, 1'b0);

    // Random traffic with random backpressure, sequence-numbered payloads.
    do_reset();
    for (int k = 0; k < N_CH; k++) seq[k] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_CH; k++) begin
        v = 1'($urandom_range(0, 1));
        drive(k, {8'(k), 24'(seq[k])}, TW'($urandom), AXW'($urandom), 1'($urandom), v);
        if (v && ready_o[k]) seq[k]++;
      end
      ready_i = 1'($urandom);
      step();
    end

    // Reset with FIFOs and output register occupied.
    ready_i = 0;
    for (int k = 0; k < N_CH; k++) drive(k, 32'hBAD0 + k, 4'h0, 6'h0, 1'b0, 1'b1);
    repeat (4) step();
    rst = 1; valid_i = '0;
    step();
    chk("t6_valid", valid_o, 1'b0);
    chk("t6_ovf", ovf_o, 4'h0);
    chk("t6_ready_low", ready_o, 4'h0);
    rst = 0; ready_i = 1;
    step();
    chk("t6_ready_high", ready_o, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_stale", valid_o, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
